// File: rtl/ssd_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with anti-ghosting blank
// time, per-frame input snapshots and leading-zero blanking.
module ssd_scan_ctrl #(
  parameter int unsigned PRESCALE  = 50000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       lzb,
  input  logic [7:0] display0,
  input  logic [7:0] display1,
  input  logic [7:0] display2,
  input  logic [7:0] display3,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int unsigned        CW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]      CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0]      CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [7:0]         GLYPH_0   = 8'b0000_0011;
  localparam logic [7:0]         SEG_OFF   = 8'hFF;
  localparam logic [3:0]         AN_OFF    = 4'b1111;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][7:0] snap_q, snap_d;
  logic [7:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic            frame_done_q, frame_done_d;

  logic            slot_wrap;
  logic            snap_load;
  logic [3:0]      digit_blank;

  assign slot_wrap = (cnt_q == CNT_LAST);
  assign snap_load = !en || ((idx_q == 2'd0) && (cnt_q == '0));

  // A digit is blanked only while every more-significant digit is blanked too,
  // so an interior zero (e.g. "1005") stays visible.
  always_comb begin
    digit_blank    = 4'b0000;
    digit_blank[3] = lzb && (snap_q[3] == GLYPH_0);
    digit_blank[2] = digit_blank[3] && (snap_q[2] == GLYPH_0);
    digit_blank[1] = digit_blank[2] && (snap_q[1] == GLYPH_0);
  end

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    seg_d        = SEG_OFF;
    an_d         = AN_OFF;
    frame_done_d = 1'b0;

    if (snap_load) begin
      snap_d = {display3, display2, display1, display0};
    end

    if (!en) begin
      state_d = BLANK;
      cnt_d   = '0;
      idx_d   = 2'd0;
    end else begin
      if (slot_wrap) begin
        cnt_d   = '0;
        idx_d   = idx_q + 2'd1;
        state_d = BLANK;
      end else begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_d == CNT_BLANK) begin
          state_d = DRIVE;
        end
      end

      frame_done_d = slot_wrap && (idx_q == 2'd3);

      if ((state_q == DRIVE) && !digit_blank[idx_q]) begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = snap_q[idx_q];
      end
    end
  end

  // NOTE: snapshots are reset to the all-off pattern so a display never flashes
  // stale data before the first frame loads; they are only four bytes of flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BLANK;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      snap_q       <= {4{SEG_OFF}};
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a time-based reference model.
module tb_ssd_scan_ctrl;

  localparam int P = 8;
  localparam int B = 2;
  localparam int FRAME = 4 * P;

  localparam logic [7:0] G0 = 8'b0000_0011;
  localparam logic [7:0] G1 = 8'b1001_1111;
  localparam logic [7:0] G2 = 8'b0010_0101;
  localparam logic [7:0] G3 = 8'b0000_1101;
  localparam logic [7:0] G4 = 8'b1001_1001;
  localparam logic [7:0] G5 = 8'b0100_1001;
  localparam logic [7:0] G7 = 8'b0001_1111;
  localparam logic [7:0] GF = 8'b0111_0001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       lzb;
  logic [7:0] d [4];
  logic [7:0] seg;
  logic [3:0] an;
  logic       frame_done;

  ssd_scan_ctrl #(.PRESCALE(P), .BLANK_CYC(B)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .lzb       (lzb),
    .display0  (d[0]),
    .display1  (d[1]),
    .display2  (d[2]),
    .display3  (d[3]),
    .seg       (seg),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: t counts enabled cycles since scanning (re)started; the
  // frame snapshot is taken from the inputs whenever t lands on a frame start.
  int         t;
  logic [7:0] ms [4];
  logic [7:0] e_seg;
  logic [3:0] e_an;
  logic       e_fd;
  int         n_chk;
  int         n_pass;
  int         n_lit [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
  endtask

  task automatic predict();
    int  slot_pos;
    int  digit;
    bit  hidden;
    e_seg = 8'hFF;
    e_an  = 4'hF;
    e_fd  = 1'b0;
    if (en) begin
      slot_pos = t % P;
      digit    = (t / P) % 4;
      hidden   = lzb && (digit > 0);
      for (int j = digit; j < 4; j++) begin
        if (ms[j] != G0) hidden = 1'b0;
      end
      if (slot_pos >= B && !hidden) begin
        e_an  = 4'hF;
        e_an[digit] = 1'b0;
        e_seg = ms[digit];
      end
      e_fd = ((t % FRAME) == FRAME - 1);
    end
  endtask

  task automatic advance_model();
    if (!en) begin
      t = 0;
      for (int j = 0; j < 4; j++) ms[j] = d[j];
    end else begin
      if ((t % FRAME) == 0) begin
        for (int j = 0; j < 4; j++) ms[j] = d[j];
      end
      t++;
    end
  endtask

  task automatic step(input string tag);
    predict();
    @(posedge clk);
    advance_model();
    #1;
    check({tag, ".an"},  32'(an),         32'(e_an));
    check({tag, ".seg"}, 32'(seg),        32'(e_seg));
    check({tag, ".fd"},  32'(frame_done), 32'(e_fd));
    for (int j = 0; j < 4; j++) begin
      if (e_an[j] == 1'b0) n_lit[j]++;
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  // Advance until the model says the next cycle is a DRIVE cycle of digit k.
  task automatic run_to_drive(input string tag, input int k);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (((t / P) % 4 == k) && ((t % P) >= B)) break;
      step(tag);
    end
  endtask

  task automatic set_digits(input logic [7:0] v3, input logic [7:0] v2,
                            input logic [7:0] v1, input logic [7:0] v0);
    d[3] = v3; d[2] = v2; d[1] = v1; d[0] = v0;
  endtask

  function automatic logic [7:0] rand_glyph();
    logic [7:0] tbl [8];
    tbl = '{G0, G1, G2, G3, G4, G7, GF, 8'hFF};
    if ($urandom_range(3) == 0) return 8'($urandom);
    return tbl[$urandom_range(7)];
  endfunction

  initial begin
    int fd_seen;
    n_chk  = 0;
    n_pass = 0;
    for (int j = 0; j < 4; j++) n_lit[j] = 0;
    t = 0;
    for (int j = 0; j < 4; j++) ms[j] = 8'hFF;

    // Reset state
    rst_n = 1'b0;
    en    = 1'b0;
    lzb   = 1'b0;
    set_digits(G4, G3, G2, G1);
    #12;
    check("reset.an",  32'(an),         32'hF);
    check("reset.seg", 32'(seg),        32'hFF);
    check("reset.fd",  32'(frame_done), 32'h0);
    rst_n = 1'b1;
    run("idle", 3);

    // Scan order with "4321"
    en = 1'b1;
    run("scan", 3 * FRAME);

    // frame_done spacing over two frames
    fd_seen = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step("fdspace");
      if (frame_done) fd_seen++;
    end
    check("fd_count", 32'(fd_seen), 32'd2);

    // Leading-zero blanking: "0007" then "0000"
    lzb = 1'b1;
    set_digits(G0, G0, G0, G7);
    for (int j = 0; j < 4; j++) n_lit[j] = 0;
    run("lzb7", 2 * FRAME);
    set_digits(G0, G0, G0, G0);
    run("lzb0", 2 * FRAME + 1);
    check("lzb.lit3", 32'(n_lit[3]), 32'd0);
    check("lzb.lit2", 32'(n_lit[2]), 32'd0);
    check("lzb.lit1", 32'(n_lit[1]), 32'd0);
    // Interior zero remains visible
    set_digits(G0, G1, G0, G0);
    run("lzb_int", 2 * FRAME);

    // Snapshot coherence: change digit 0 mid-frame
    lzb = 1'b0;
    set_digits(G4, G3, G2, G1);
    run("snap_pre", FRAME);
    run_to_drive("snap_seek", 2);
    d[0] = G5;
    run("snap", 2 * FRAME);

    // Enable drop during DRIVE of digit 2, then restart
    run_to_drive("en_seek", 2);
    step("en_drive");
    en = 1'b0;
    step("en_off");
    check("en_off.an", 32'(an), 32'hF);
    run("en_idle", 5);
    en = 1'b1;
    run("en_restart", FRAME + 4);

    // Asynchronous reset mid-DRIVE
    run_to_drive("rst_seek", 1);
    step("rst_drive");
    #2;
    rst_n = 1'b0;
    t = 0;
    for (int j = 0; j < 4; j++) ms[j] = 8'hFF;
    #1;
    check("async.an",  32'(an),         32'hF);
    check("async.seg", 32'(seg),        32'hFF);
    check("async.fd",  32'(frame_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run("rst_restart", FRAME + 4);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(19) == 0) begin
        for (int j = 0; j < 4; j++) d[j] = rand_glyph();
      end
      if ($urandom_range(29) == 0) lzb = ~lzb;
      if ($urandom_range(99) == 0) en = ~en;
      else if (!en && $urandom_range(3) == 0) en = 1'b1;
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
